ram_arbiter: RTL

Two-port arbiter and access sequencer that shares the single synchronous `ram` (1-cycle registered read) between two requesters, for example a cache refill/write-back path and a DMA or second cache. It accepts one request at a time and grants it by round-robin or fixed priority. It then drives the RAM enables, address and data from latched command registers and returns read data with a valid pulse to the port that owns the access. It sits between the requesters and the `ram` instance.

---
 rtl/ram_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter and access sequencer in front of a single-port synchronous RAM
// with a 1-cycle registered read. One access at a time; round-robin or fixed priority.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic                  owner_q,      owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  cmd_we_q,     cmd_we_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q,   cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_wdata_q,  cmd_wdata_d;
    logic                  rvalid0_q,    rvalid0_d;
    logic                  rvalid1_q,    rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q,     rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q,     rdata1_d;

    logic win;

    // Winner is only consumed in IDLE with at least one request present.
    always_comb begin
        win = 1'b0;
        if (ARB_MODE == 1) begin
            win = !req0;
        end else if (req0 && req1) begin
            win = !last_owner_q;
        end else begin
            win = req1;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cmd_we_d     = cmd_we_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d      = win;
                    last_owner_d = win;
                    cmd_we_d     = win ? we1 : we0;
                    cmd_addr_d   = win ? addr1 : addr0;
                    cmd_wdata_d  = win ? wdata1 : wdata0;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                state_d = cmd_we_q ? IDLE : RESP;
            end
            RESP: begin
                if (owner_q) begin
                    rdata1_d  = ram_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = ram_rdata;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Everything below decodes registered state only, so reset clears the RAM
    // enables immediately and no request input reaches an output combinationally.
    assign gnt0      = (state_q == ACCESS) && !owner_q;
    assign gnt1      = (state_q == ACCESS) && owner_q;
    assign ram_we    = (state_q == ACCESS) && cmd_we_q;
    assign ram_re    = (state_q == ACCESS) && !cmd_we_q;
    assign ram_addr  = cmd_addr_q;
    assign ram_wdata = cmd_wdata_q;
    assign busy      = (state_q != IDLE);
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

    a_gnt_excl: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
    a_rvalid_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rvalid0 && rvalid1));
    a_ram_en_excl: assert property (@(posedge clk) disable iff (!rst_n) !(ram_we && ram_re));
    a_gnt_has_en: assert property (@(posedge clk) disable iff (!rst_n) ((gnt0 || gnt1) == (ram_we || ram_re)));

endmodule
